md5_block_feeder: RTL and testbench

Message-side front end for the hyper-pipelined MD5 core wrapper (`top`). Accepts a byte-oriented message as a stream of 32-bit little-endian words and performs MD5 padding and length append. Emits each 512-bit block on `WB_OUT`, one-cycle strobed, together with its input chaining value on `A_OUT`..`D_OUT`:
- first block of a message: MD5 IV;
- later blocks: the chaining value returned by the downstream digest adder.

---
 rtl/md5_block_feeder_if.sv | 29 ++
 rtl/md5_block_feeder.sv | 172 +++++++++++++++++
 tb/tb_md5_block_feeder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/md5_block_feeder_if.sv
// Stream, chain-return and block-output signals of the MD5 block feeder.
// slave is the feeder side; master is the driver/core side.
interface md5_block_feeder_if;
  logic [31:0]  S_DATA;
  logic         S_VALID;
  logic         S_LAST;
  logic [1:0]   S_BYTES;
  logic         S_READY;
  logic         CHAIN_VALID;
  logic [31:0]  CHAIN_A, CHAIN_B, CHAIN_C, CHAIN_D;
  logic [511:0] WB_OUT;
  logic [31:0]  A_OUT, B_OUT, C_OUT, D_OUT;
  logic         BLK_VALID;
  logic         BLK_LAST;

  modport slave (
    input  S_DATA, S_VALID, S_LAST, S_BYTES,
    output S_READY,
    input  CHAIN_VALID, CHAIN_A, CHAIN_B, CHAIN_C, CHAIN_D,
    output WB_OUT, A_OUT, B_OUT, C_OUT, D_OUT, BLK_VALID, BLK_LAST
  );

  modport master (
    output S_DATA, S_VALID, S_LAST, S_BYTES,
    input  S_READY,
    output CHAIN_VALID, CHAIN_A, CHAIN_B, CHAIN_C, CHAIN_D,
    input  WB_OUT, A_OUT, B_OUT, C_OUT, D_OUT, BLK_VALID, BLK_LAST
  );
endinterface

// File: rtl/md5_block_feeder.sv
// MD5 message front end: packs LE words into 512-bit blocks, applies padding
// and length, and pairs each block with IV or the returned chaining value.
module md5_block_feeder #(
  parameter int LEN_BYTES_W = 32
) (
  input logic          CLK,
  input logic          RST,
  md5_block_feeder_if.slave bus
);
  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } chain_t;

  localparam chain_t IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476};

  state_t                  state_q, state_nx;
  logic [15:0][31:0]       blk_q, blk_nx;
  logic [3:0]              idx_q, idx_nx;
  logic [LEN_BYTES_W-1:0]  cnt_q, cnt_nx, cnt_sum;
  logic                    first_q, first_nx;
  logic                    pend_q, pend_nx;
  logic                    last_q, last_nx;
  logic                    extra_q, extra_nx;
  logic                    pad16_q, pad16_nx;
  chain_t                  chain_q, chain_nx;
  logic [15:0][31:0]       wb_q;
  chain_t                  cv_q;
  chain_t                  cur_chain, chain_out;
  logic                    fire;
  logic [2:0]              nbytes;
  logic [4:0]              pad_idx;
  logic [31:0]             word;
  logic [63:0]             len_bits;

  assign cur_chain = first_q ? IV : chain_q;

  always_comb begin
    state_nx = state_q;
    blk_nx   = blk_q;
    idx_nx   = idx_q;
    cnt_nx   = cnt_q;
    first_nx = first_q;
    pend_nx  = pend_q;
    last_nx  = last_q;
    extra_nx = extra_q;
    pad16_nx = pad16_q;
    chain_nx = chain_q;
    fire     = 1'b0;

    nbytes   = (bus.S_LAST && bus.S_BYTES != 2'd0) ? {1'b0, bus.S_BYTES} : 3'd4;
    pad_idx  = {1'b0, idx_q} + ((nbytes == 3'd4) ? 5'd1 : 5'd0);
    cnt_sum  = cnt_q + LEN_BYTES_W'(nbytes);
    // EXTRA uses the already-committed count; FILL needs it including this word
    len_bits = 64'((state_q == EXTRA) ? cnt_q : cnt_sum) << 3;

    case (nbytes)
      3'd1:    word = {16'h0, 8'h80, bus.S_DATA[7:0]};
      3'd2:    word = {8'h0, 8'h80, bus.S_DATA[15:0]};
      3'd3:    word = {8'h80, bus.S_DATA[23:0]};
      default: word = bus.S_DATA;
    endcase

    if (bus.CHAIN_VALID && pend_q) begin
      chain_nx = {bus.CHAIN_A, bus.CHAIN_B, bus.CHAIN_C, bus.CHAIN_D};
      pend_nx  = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (bus.S_VALID) begin
          cnt_nx        = cnt_sum;
          blk_nx[idx_q] = word;
          if (!bus.S_LAST) begin
            if (idx_q == 4'd15) begin
              state_nx = EMIT;
              last_nx  = 1'b0;
              extra_nx = 1'b0;
            end else begin
              idx_nx = idx_q + 4'd1;
            end
          end else begin
            // a full last word pushes the 0x80 marker into the following slot
            for (int i = 0; i < 16; i++) begin
              if (5'(i) > pad_idx)
                blk_nx[i] = '0;
              else if (5'(i) == pad_idx && nbytes == 3'd4)
                blk_nx[i] = 32'h0000_0080;
            end
            if (pad_idx <= 5'd13) begin
              blk_nx[14] = len_bits[31:0];
              blk_nx[15] = len_bits[63:32];
              last_nx    = 1'b1;
              extra_nx   = 1'b0;
            end else begin
              last_nx    = 1'b0;
              extra_nx   = 1'b1;
              pad16_nx   = (pad_idx == 5'd16);
            end
            state_nx = EMIT;
          end
        end
      end
      EMIT: begin
        if (!pend_q) begin
          fire     = 1'b1;
          pend_nx  = !last_q;
          first_nx = last_q;
          idx_nx   = '0;
          if (last_q) cnt_nx = '0;
          state_nx = extra_q ? EXTRA : FILL;
        end
      end
      EXTRA: begin
        blk_nx     = '0;
        blk_nx[0]  = pad16_q ? 32'h0000_0080 : 32'h0;
        blk_nx[14] = len_bits[31:0];
        blk_nx[15] = len_bits[63:32];
        last_nx    = 1'b1;
        extra_nx   = 1'b0;
        state_nx   = EMIT;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FILL;
      blk_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      pad16_q <= 1'b0;
      chain_q <= '0;
      wb_q    <= '0;
      cv_q    <= '0;
    end else begin
      state_q <= state_nx;
      blk_q   <= blk_nx;
      idx_q   <= idx_nx;
      cnt_q   <= cnt_nx;
      first_q <= first_nx;
      pend_q  <= pend_nx;
      last_q  <= last_nx;
      extra_q <= extra_nx;
      pad16_q <= pad16_nx;
      chain_q <= chain_nx;
      if (fire) begin
        wb_q <= blk_q;
        cv_q <= cur_chain;
      end
    end
  end

  // outputs show the live block on the strobe cycle and hold it afterwards
  assign chain_out     = RST ? '0 : (fire ? cur_chain : cv_q);
  assign bus.S_READY   = !RST && (state_q == FILL);
  assign bus.BLK_VALID = !RST && fire;
  assign bus.BLK_LAST  = !RST && fire && last_q;
  assign bus.WB_OUT    = RST ? '0 : (fire ? blk_q : wb_q);
  assign bus.A_OUT     = chain_out.a;
  assign bus.B_OUT     = chain_out.b;
  assign bus.C_OUT     = chain_out.c;
  assign bus.D_OUT     = chain_out.d;
endmodule

// File: tb/tb_md5_block_feeder.sv
// Directed bench for md5_block_feeder: padding boundaries, chain handshake,
// IV selection and reset behaviour with hand-computed blocks.
module tb_md5_block_feeder;
  logic CLK = 1'b0;
  logic RST;
  md5_block_feeder_if bus();

  md5_block_feeder #(.LEN_BYTES_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  localparam logic [127:0] IVV = 128'h67452301_EFCDAB89_98BADCFE_10325476;
  localparam logic [127:0] CH1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] CH2 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] CH3 = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;

  int nerr = 0;
  int nchk = 0;
  int nblk = 0;
  logic [15:0][31:0] e;
  logic bad;
  int n0;

  always @(posedge CLK) if (bus.BLK_VALID === 1'b1) nblk++;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic logic [31:0] dw(input int i);
    return {8'(i), 8'hC3, 8'(i + 1), 8'h5A};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called right after a negedge; returns 1 ns after the negedge following acceptance
  task automatic put(input logic [31:0] d, input logic l, input logic [1:0] b);
    int n;
    n = 0;
    bus.S_DATA = d; bus.S_LAST = l; bus.S_BYTES = b; bus.S_VALID = 1'b1;
    #1;
    while (bus.S_READY !== 1'b1 && n < 300) begin
      @(negedge CLK); #1; n++;
    end
    if (n >= 300) begin
      nchk++; nerr++;
      $display("FAIL ready_timeout: observed=0 expected=1");
    end
    @(negedge CLK);
    bus.S_VALID = 1'b0; bus.S_LAST = 1'b0; bus.S_BYTES = 2'd0;
    #1;
  endtask

  task automatic chain_out_chk(input string tag, input logic [127:0] exp);
    chk(tag, {bus.A_OUT, bus.B_OUT, bus.C_OUT, bus.D_OUT}, exp);
  endtask

  initial begin
    RST = 1'b1;
    bus.S_DATA = '0; bus.S_VALID = 1'b0; bus.S_LAST = 1'b0; bus.S_BYTES = 2'd0;
    bus.CHAIN_VALID = 1'b0;
    bus.CHAIN_A = '0; bus.CHAIN_B = '0; bus.CHAIN_C = '0; bus.CHAIN_D = '0;
    @(negedge CLK); @(negedge CLK); #1;
    chk("rst_ready", bus.S_READY, 1'b0);
    chk("rst_valid", bus.BLK_VALID, 1'b0);
    chk("rst_wb", bus.WB_OUT, '0);
    chain_out_chk("rst_chain", '0);
    @(negedge CLK); RST = 1'b0; #1;
    chk("ready_after_rst", bus.S_READY, 1'b1);

    // "abc"
    put(32'h00636261, 1'b1, 2'd3);
    e = '0; e[0] = 32'h80636261; e[14] = 32'h18;
    chk("abc_valid", bus.BLK_VALID, 1'b1);
    chk("abc_last", bus.BLK_LAST, 1'b1);
    chk("abc_wb", bus.WB_OUT, e);
    chain_out_chk("abc_iv", IVV);
    @(negedge CLK); #1;
    chk("abc_strobe_once", bus.BLK_VALID, 1'b0);
    chk("abc_wb_hold", bus.WB_OUT, e);
    chain_out_chk("abc_iv_hold", IVV);
    chk("abc_ready_back", bus.S_READY, 1'b1);

    // 55 bytes: pad marker in the top byte of word 13
    n0 = nblk;
    for (int i = 0; i < 13; i++) put(dw(i), 1'b0, 2'd0);
    put(32'hFF112233, 1'b1, 2'd3);
    e = '0;
    for (int i = 0; i < 13; i++) e[i] = dw(i);
    e[13] = 32'h80112233; e[14] = 32'h1B8;
    chk("m55_valid", bus.BLK_VALID, 1'b1);
    chk("m55_last", bus.BLK_LAST, 1'b1);
    chk("m55_wb", bus.WB_OUT, e);
    chain_out_chk("m55_iv", IVV);
    repeat (3) @(negedge CLK);
    #1;
    chk("m55_one_block", nblk - n0, 1);

    // 56 bytes: length spills into an extra block
    for (int i = 0; i < 13; i++) put(dw(i), 1'b0, 2'd0);
    put(dw(13), 1'b1, 2'd0);
    e = '0;
    for (int i = 0; i < 14; i++) e[i] = dw(i);
    e[14] = 32'h80;
    chk("m56_b0_valid", bus.BLK_VALID, 1'b1);
    chk("m56_b0_last", bus.BLK_LAST, 1'b0);
    chk("m56_b0_wb", bus.WB_OUT, e);
    chain_out_chk("m56_b0_iv", IVV);
    bad = 1'b0;
    repeat (8) begin
      @(negedge CLK); #1;
      if (bus.BLK_VALID !== 1'b0 || bus.S_READY !== 1'b0) bad = 1'b1;
    end
    chk("m56_wait_chain", bad, 1'b0);
    {bus.CHAIN_A, bus.CHAIN_B, bus.CHAIN_C, bus.CHAIN_D} = CH1;
    bus.CHAIN_VALID = 1'b1;
    chk("m56_no_strobe_on_chain", bus.BLK_VALID, 1'b0);
    @(negedge CLK); #1;
    bus.CHAIN_VALID = 1'b0;
    e = '0; e[14] = 32'h1C0;
    chk("m56_b1_valid", bus.BLK_VALID, 1'b1);
    chk("m56_b1_last", bus.BLK_LAST, 1'b1);
    chk("m56_b1_wb", bus.WB_OUT, e);
    chain_out_chk("m56_b1_chain", CH1);

    // 64 bytes: marker lands as word 0 of the extra block
    @(negedge CLK); #1;
    for (int i = 0; i < 15; i++) put(dw(i), 1'b0, 2'd0);
    put(dw(15), 1'b1, 2'd0);
    e = '0;
    for (int i = 0; i < 16; i++) e[i] = dw(i);
    chk("m64_b0_valid", bus.BLK_VALID, 1'b1);
    chk("m64_b0_last", bus.BLK_LAST, 1'b0);
    chk("m64_b0_wb", bus.WB_OUT, e);
    chain_out_chk("m64_b0_iv", IVV);
    bad = 1'b0;
    repeat (20) begin
      @(negedge CLK); #1;
      if (bus.BLK_VALID !== 1'b0 || bus.S_READY !== 1'b0) bad = 1'b1;
    end
    chk("m64_wait_chain", bad, 1'b0);
    {bus.CHAIN_A, bus.CHAIN_B, bus.CHAIN_C, bus.CHAIN_D} = CH2;
    bus.CHAIN_VALID = 1'b1;
    @(negedge CLK); #1;
    bus.CHAIN_VALID = 1'b0;
    e = '0; e[0] = 32'h80; e[14] = 32'h200;
    chk("m64_b1_valid", bus.BLK_VALID, 1'b1);
    chk("m64_b1_last", bus.BLK_LAST, 1'b1);
    chk("m64_b1_wb", bus.WB_OUT, e);
    chain_out_chk("m64_b1_chain", CH2);
    chk("m64_ready_emit", bus.S_READY, 1'b0);

    // 65 bytes: chain returns while the second block is still filling
    @(negedge CLK); #1;
    for (int i = 0; i < 16; i++) put(dw(i), 1'b0, 2'd0);
    e = '0;
    for (int i = 0; i < 16; i++) e[i] = dw(i);
    chk("m65_b0_valid", bus.BLK_VALID, 1'b1);
    chk("m65_b0_last", bus.BLK_LAST, 1'b0);
    chk("m65_b0_wb", bus.WB_OUT, e);
    chain_out_chk("m65_b0_iv", IVV);
    @(negedge CLK); #1;
    {bus.CHAIN_A, bus.CHAIN_B, bus.CHAIN_C, bus.CHAIN_D} = CH3;
    bus.CHAIN_VALID = 1'b1;
    put(32'h123456AB, 1'b1, 2'd1);
    bus.CHAIN_VALID = 1'b0;
    e = '0; e[0] = 32'h000080AB; e[14] = 32'h208;
    chk("m65_b1_valid", bus.BLK_VALID, 1'b1);
    chk("m65_b1_last", bus.BLK_LAST, 1'b1);
    chk("m65_b1_wb", bus.WB_OUT, e);
    chain_out_chk("m65_b1_chain", CH3);

    // spurious chain with nothing pending
    @(negedge CLK); #1;
    {bus.CHAIN_A, bus.CHAIN_B, bus.CHAIN_C, bus.CHAIN_D} = {4{32'hDEADBEEF}};
    bus.CHAIN_VALID = 1'b1;
    @(negedge CLK); #1;
    bus.CHAIN_VALID = 1'b0;
    put(32'h00636261, 1'b1, 2'd3);
    e = '0; e[0] = 32'h80636261; e[14] = 32'h18;
    chk("spur_valid", bus.BLK_VALID, 1'b1);
    chk("spur_wb", bus.WB_OUT, e);
    chain_out_chk("spur_iv", IVV);

    // reset after 20 words of a 100-byte message
    @(negedge CLK); #1;
    for (int i = 0; i < 20; i++) put(dw(i), 1'b0, 2'd0);
    RST = 1'b1;
    #1;
    chk("mid_rst_ready", bus.S_READY, 1'b0);
    chk("mid_rst_valid", bus.BLK_VALID, 1'b0);
    chk("mid_rst_wb", bus.WB_OUT, '0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("mid_ready_after", bus.S_READY, 1'b1);
    n0 = nblk;
    put(32'h00636261, 1'b1, 2'd3);
    e = '0; e[0] = 32'h80636261; e[14] = 32'h18;
    chk("mid_abc_valid", bus.BLK_VALID, 1'b1);
    chk("mid_abc_last", bus.BLK_LAST, 1'b1);
    chk("mid_abc_wb", bus.WB_OUT, e);
    chain_out_chk("mid_abc_iv", IVV);
    repeat (5) @(negedge CLK);
    #1;
    chk("mid_one_block", nblk - n0, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
